// File: rtl/gt1_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gt1_loader : walks a GT1 image in the option ROM and writes it into main RAM
// Revision   : 1.0
// ---------------------------------------------------------------------------
module gt1_loader #(
  parameter int          ROM_LAST     = 9866,
  parameter logic [7:0]  RAM_TOP_PAGE = 8'h7F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] rom_address,
  input  logic [7:0]  rom_data,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] exec_addr,
  output logic        exec_valid
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_HI      = 4'd1;
  localparam logic [3:0] S_LO      = 4'd2;
  localparam logic [3:0] S_SIZE    = 4'd3;
  localparam logic [3:0] S_DATA    = 4'd4;
  localparam logic [3:0] S_EXEC_HI = 4'd5;
  localparam logic [3:0] S_EXEC_LO = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERROR   = 4'd8;

  localparam logic [15:0] ROM_LAST_A = 16'(ROM_LAST);

  logic [3:0]  state_q, state_d;
  logic [15:0] rom_address_q, rom_address_d;
  logic        first_q, first_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  offset_q, offset_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        ram_we_q, ram_we_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_data_q, ram_data_d;
  logic [7:0]  exec_hi_q, exec_hi_d;
  logic [15:0] exec_addr_q, exec_addr_d;
  logic        exec_valid_q, exec_valid_d;

  logic        overrun;
  logic [8:0]  seg_size;
  logic [9:0]  seg_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rom_address_q <= 16'd0;
      first_q       <= 1'b0;
      page_q        <= 8'd0;
      offset_q      <= 8'd0;
      cnt_q         <= 9'd0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= 16'd0;
      ram_data_q    <= 8'd0;
      exec_hi_q     <= 8'd0;
      exec_addr_q   <= 16'd0;
      exec_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_address_q <= rom_address_d;
      first_q       <= first_d;
      page_q        <= page_d;
      offset_q      <= offset_d;
      cnt_q         <= cnt_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_q    <= ram_data_d;
      exec_hi_q     <= exec_hi_d;
      exec_addr_q   <= exec_addr_d;
      exec_valid_q  <= exec_valid_d;
    end
  end

  always_comb begin
    overrun  = (rom_address_q > ROM_LAST_A);
    seg_size = (rom_data == 8'd0) ? 9'd256 : {1'b0, rom_data};
    seg_end  = {2'b00, offset_q} + {1'b0, seg_size};

    state_d       = state_q;
    rom_address_d = rom_address_q;
    first_d       = first_q;
    page_d        = page_q;
    offset_d      = offset_q;
    cnt_d         = cnt_q;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_data_d    = ram_data_q;
    exec_hi_d     = exec_hi_q;
    exec_addr_d   = exec_addr_q;
    exec_valid_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          rom_address_d = 16'd0;
          first_d       = 1'b1;
          state_d       = S_HI;
        end
      end
      S_HI: begin
        if (overrun) begin
          state_d = S_ERROR;
        end else begin
          rom_address_d = rom_address_q + 16'd1;
          // A zero page byte only terminates once a segment has been seen
          if (rom_data == 8'd0 && !first_q) begin
            state_d = S_EXEC_HI;
          end else if (rom_data > RAM_TOP_PAGE) begin
            state_d = S_ERROR;
          end else begin
            page_d  = rom_data;
            first_d = 1'b0;
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (overrun) begin
          state_d = S_ERROR;
        end else begin
          rom_address_d = rom_address_q + 16'd1;
          offset_d      = rom_data;
          state_d       = S_SIZE;
        end
      end
      S_SIZE: begin
        if (overrun) begin
          state_d = S_ERROR;
        end else begin
          rom_address_d = rom_address_q + 16'd1;
          cnt_d         = seg_size;
          state_d       = (seg_end > 10'd256) ? S_ERROR : S_DATA;
        end
      end
      S_DATA: begin
        if (overrun) begin
          state_d = S_ERROR;
        end else begin
          rom_address_d = rom_address_q + 16'd1;
          ram_we_d      = 1'b1;
          ram_addr_d    = {page_q, offset_q};
          ram_data_d    = rom_data;
          offset_d      = offset_q + 8'd1;
          cnt_d         = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = S_HI;
        end
      end
      S_EXEC_HI: begin
        if (overrun) begin
          state_d = S_ERROR;
        end else begin
          rom_address_d = rom_address_q + 16'd1;
          exec_hi_d     = rom_data;
          state_d       = S_EXEC_LO;
        end
      end
      S_EXEC_LO: begin
        if (overrun) begin
          state_d = S_ERROR;
        end else begin
          rom_address_d = rom_address_q + 16'd1;
          exec_addr_d   = {exec_hi_q, rom_data};
          exec_valid_d  = 1'b1;
          state_d       = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    cpu_hold    = busy;
    done        = (state_q == S_DONE);
    error       = (state_q == S_ERROR);
    rom_address = rom_address_q;
    ram_we      = ram_we_q;
    ram_addr    = ram_addr_q;
    ram_data    = ram_data_q;
    exec_addr   = exec_addr_q;
    exec_valid  = exec_valid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_gt1_loader.sv
`default_nettype none
// tb_gt1_loader : directed self-checking bench for gt1_loader.
module tb_gt1_loader;
  localparam int ROM_LAST = 271;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] rom_address;
  logic [7:0]  rom_data;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        cpu_hold, busy, done, error, exec_valid;
  logic [15:0] exec_addr;

  logic [7:0]  rom [0:511];
  assign rom_data = rom[rom_address[8:0]];

  gt1_loader #(.ROM_LAST(ROM_LAST), .RAM_TOP_PAGE(8'h7F)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_address(rom_address), .rom_data(rom_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .exec_addr(exec_addr), .exec_valid(exec_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int base = 0;
  int n_wr = 0;
  int ev_cnt = 0;
  int ev_cyc = 0;
  logic [15:0] wr_addr [0:2047];
  logic [7:0]  wr_data [0:2047];
  int          wr_cyc  [0:2047];

  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (n_wr < 2048) begin
        wr_addr[n_wr] = ram_addr;
        wr_data[n_wr] = ram_data;
        wr_cyc[n_wr]  = cyc - base;
      end
      n_wr = n_wr + 1;
    end
    if (exec_valid === 1'b1) begin
      ev_cnt = ev_cnt + 1;
      ev_cyc = cyc - base;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = 8'h00;
  endtask

  task automatic load_full_page();
    clear_rom();
    rom[0] = 8'h05; rom[1] = 8'h00; rom[2] = 8'h00;
    for (int i = 0; i < 256; i++) rom[3 + i] = 8'(i) ^ 8'hA5;
    rom[259] = 8'h06; rom[260] = 8'h10; rom[261] = 8'h01; rom[262] = 8'h77;
    rom[263] = 8'h00; rom[264] = 8'h12; rom[265] = 8'h34;
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    base  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output bit ok, output int end_cyc);
    ok = 1'b0;
    end_cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1 || error === 1'b1) begin
        ok = 1'b1;
        end_cyc = cyc - base;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ram_we, cpu_hold, busy, done, error, exec_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {ram_we, cpu_hold, busy, done, error, exec_valid});
    end
    checks++;
    if ({rom_address, ram_addr, ram_data, exec_addr} !== 56'h0) begin
      errors++;
      $display("FAIL reset_buses: got %h expected 0",
               {rom_address, ram_addr, ram_data, exec_addr});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; int ec; int wb; int eb;
    clear_rom();
    rom[0] = 8'h02; rom[1] = 8'h00; rom[2] = 8'h03; rom[3] = 8'hAA; rom[4] = 8'hBB;
    rom[5] = 8'hCC; rom[6] = 8'h00; rom[7] = 8'h02; rom[8] = 8'h00;
    wb = n_wr; eb = ev_cnt;
    start_load();
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got busy=%b hold=%b expected 1 1", busy, cpu_hold);
    end
    wait_end(ok, ec);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || ec != 10) begin
      errors++;
      $display("FAIL basic_end_cycle: got %0d expected 10", ec);
    end
    checks++;
    if (n_wr - wb != 3) begin
      errors++;
      $display("FAIL basic_wr_count: got %0d expected 3", n_wr - wb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [7:0] exp_d;
        exp_d = (i == 0) ? 8'hAA : (i == 1) ? 8'hBB : 8'hCC;
        checks++;
        if (wr_addr[wb+i] !== 16'h0200 + 16'(i) || wr_data[wb+i] !== exp_d || wr_cyc[wb+i] != 5 + i) begin
          errors++;
          $display("FAIL basic_write%0d: got %h=%h @%0d expected %h=%h @%0d", i,
                   wr_addr[wb+i], wr_data[wb+i], wr_cyc[wb+i], 16'h0200 + 16'(i), exp_d, 5 + i);
        end
      end
    end
    checks++;
    if (ev_cnt - eb != 1 || ev_cyc != 10) begin
      errors++;
      $display("FAIL basic_exec_valid: got %0d pulses @%0d expected 1 @10", ev_cnt - eb, ev_cyc);
    end
    checks++;
    if (exec_addr !== 16'h0200 || done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL basic_final: got exec=%h done=%b hold=%b err=%b expected 0200 1 0 0",
               exec_addr, done, cpu_hold, error);
    end
    checks++;
    if (rom_address !== 16'd9) begin
      errors++;
      $display("FAIL basic_rom_hold: got %0d expected 9", rom_address);
    end
  endtask

  task automatic test_zero_page();
    bit ok; int ec; int wb;
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h30; rom[2] = 8'h02; rom[3] = 8'h11;
    rom[4] = 8'h22; rom[5] = 8'h00; rom[6] = 8'h01; rom[7] = 8'h00;
    wb = n_wr;
    start_load();
    wait_end(ok, ec);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || n_wr - wb != 2 || wr_addr[wb] !== 16'h0030 || wr_data[wb] !== 8'h11 ||
        wr_addr[wb+1] !== 16'h0031 || wr_data[wb+1] !== 8'h22) begin
      errors++;
      $display("FAIL zero_page_writes: got n=%0d %h=%h %h=%h expected 2 0030=11 0031=22",
               n_wr - wb, wr_addr[wb], wr_data[wb], wr_addr[wb+1], wr_data[wb+1]);
    end
    checks++;
    if (exec_addr !== 16'h0100 || done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL zero_page_exec: got %h done=%b err=%b expected 0100 1 0", exec_addr, done, error);
    end
  endtask

  task automatic test_full_page();
    bit ok; int ec; int wb; int bad;
    load_full_page();
    wb = n_wr;
    start_load();
    wait_end(ok, ec);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || n_wr - wb != 257) begin
      errors++;
      $display("FAIL full_page_count: got %0d expected 257", n_wr - wb);
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (wr_addr[wb+i] !== 16'h0500 + 16'(i) || wr_data[wb+i] !== (8'(i) ^ 8'hA5)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL full_page_data: got %0d bad writes expected 0", bad);
      end
      checks++;
      if (wr_addr[wb+256] !== 16'h0610 || wr_data[wb+256] !== 8'h77) begin
        errors++;
        $display("FAIL full_page_resume: got %h=%h expected 0610=77", wr_addr[wb+256], wr_data[wb+256]);
      end
    end
    checks++;
    if (exec_addr !== 16'h1234 || done !== 1'b1) begin
      errors++;
      $display("FAIL full_page_exec: got %h done=%b expected 1234 1", exec_addr, done);
    end
  endtask

  task automatic test_page_cross();
    bit ok; int ec; int wb; int eb;
    clear_rom();
    rom[0] = 8'h03; rom[1] = 8'hF0; rom[2] = 8'h20; rom[3] = 8'h55; rom[4] = 8'h66;
    wb = n_wr; eb = ev_cnt;
    start_load();
    wait_end(ok, ec);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || ec != 4 || error !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL page_cross_error: got cyc=%0d err=%b done=%b expected 4 1 0", ec, error, done);
    end
    checks++;
    if (n_wr - wb != 0 || ev_cnt - eb != 0 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL page_cross_quiet: got wr=%0d ev=%0d hold=%b busy=%b expected 0 0 0 0",
               n_wr - wb, ev_cnt - eb, cpu_hold, busy);
    end
    checks++;
    if (rom_address !== 16'd3 || exec_addr !== 16'h1234) begin
      errors++;
      $display("FAIL page_cross_regs: got rom=%0d exec=%h expected 3 1234", rom_address, exec_addr);
    end
  endtask

  task automatic test_truncated();
    bit ok; int ec; int wb; int beyond;
    clear_rom();
    rom[0] = 8'h01; rom[1] = 8'h00; rom[2] = 8'h00;
    for (int i = 0; i < 256; i++) rom[3 + i] = 8'(i);
    for (int s = 0; s < 3; s++) begin
      rom[259 + 4*s] = 8'h02;
      rom[260 + 4*s] = 8'(s);
      rom[261 + 4*s] = 8'h01;
      rom[262 + 4*s] = 8'hE1 + 8'(s);
    end
    rom[271] = 8'h03;
    wb = n_wr;
    start_load();
    wait_end(ok, ec);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || ec != 274 || error !== 1'b1 || done !== 1'b0 || rom_address !== 16'd272) begin
      errors++;
      $display("FAIL truncated_error: got cyc=%0d err=%b done=%b rom=%0d expected 274 1 0 272",
               ec, error, done, rom_address);
    end
    beyond = 0;
    for (int i = wb; i < n_wr; i++) if (wr_addr[i] > 16'h0202) beyond++;
    checks++;
    if (n_wr - wb != 259 || beyond != 0) begin
      errors++;
      $display("FAIL truncated_writes: got n=%0d beyond=%0d expected 259 0", n_wr - wb, beyond);
    end
    checks++;
    if (wr_addr[n_wr-1] !== 16'h0202 || wr_data[n_wr-1] !== 8'hE3) begin
      errors++;
      $display("FAIL truncated_last: got %h=%h expected 0202=E3", wr_addr[n_wr-1], wr_data[n_wr-1]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int ec; int wb; int eb; int nw; int k;
    load_full_page();
    wb = n_wr;
    start_load();
    k = 0;
    while (n_wr - wb < 20 && k < 500) begin @(negedge clk); k++; end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ram_we, cpu_hold, busy, done, error, exec_valid} !== 6'b0 ||
        {rom_address, ram_addr, ram_data, exec_addr} !== 56'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got flags=%b buses=%h expected 0 0",
               {ram_we, cpu_hold, busy, done, error, exec_valid},
               {rom_address, ram_addr, ram_data, exec_addr});
    end
    nw = n_wr;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (n_wr != nw || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d extra writes busy=%b expected 0 0", n_wr - nw, busy);
    end
    wb = n_wr; eb = ev_cnt;
    start_load();
    k = 0;
    while (n_wr - wb < 60 && k < 500) begin @(negedge clk); k++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(ok, ec);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || n_wr - wb != 257 || ev_cnt - eb != 1) begin
      errors++;
      $display("FAIL reset_mid_reload: got wr=%0d ev=%0d expected 257 1", n_wr - wb, ev_cnt - eb);
    end
    checks++;
    if (wr_addr[wb] !== 16'h0500 || wr_data[wb] !== 8'hA5 || exec_addr !== 16'h1234 || done !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_final: got first=%h=%h exec=%h done=%b expected 0500=A5 1234 1",
               wr_addr[wb], wr_data[wb], exec_addr, done);
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_basic();
    test_zero_page();
    test_full_page();
    test_page_cross();
    test_truncated();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
